// File: rtl/smpl_seq_queue.sv
// Stereo sample queue: writes continuously into a circular buffer and, on each decimated trigger,
// reads out the most recent SEQ_LEN samples oldest-first.
module smpl_seq_queue #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned SEQ_LEN = 1021,
  parameter int unsigned DECIM   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt_smpl,
  input  logic [DATA_W-1:0] lft_smpl,
  input  logic [DATA_W-1:0] rght_smpl,
  input  logic              flush,
  input  logic              clr_ovr,
  output logic [DATA_W-1:0] lft_out,
  output logic [DATA_W-1:0] rght_out,
  output logic              sequencing,
  output logic              smpl_vld,
  output logic              full,
  output logic [ADDR_W:0]   fill_cnt,
  output logic              ovr
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic {StIdle, StSeq} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W-1:0]   r_rd_cnt;
  logic [ADDR_W:0]     r_fill_cnt;
  logic [DCNT_W-1:0]   r_dcnt;
  logic                r_ovr;
  logic                r_smpl_vld;
  logic [DATA_W-1:0]   r_lft_out;
  logic [DATA_W-1:0]   r_rght_out;
  logic [DATA_W-1:0]   r_mem_l [DEPTH];
  logic [DATA_W-1:0]   r_mem_r [DEPTH];

  logic w_wr;
  logic w_qual;
  logic w_trig;

  // flush discards a same-cycle write
  assign w_wr   = wrt_smpl & ~flush;
  assign w_qual = w_wr && (r_fill_cnt >= (ADDR_W + 1)'(SEQ_LEN - 1));
  assign w_trig = w_qual && (r_dcnt == DCNT_W'(DECIM - 1));

  // Storage is never reset; the fill count keeps stale entries out of any window.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_l[r_wr_ptr] <= lft_smpl;
      r_mem_r[r_wr_ptr] <= rght_smpl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lft_out  <= '0;
      r_rght_out <= '0;
    end else if (r_state == StSeq && !flush) begin
      r_lft_out  <= r_mem_l[r_rd_ptr];
      r_rght_out <= r_mem_r[r_rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_dcnt     <= '0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_dcnt     <= '0;
    end else if (w_wr) begin
      r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (r_fill_cnt != (ADDR_W + 1)'(SEQ_LEN)) begin
        r_fill_cnt <= r_fill_cnt + (ADDR_W + 1)'(1);
      end
      if (w_qual) begin
        r_dcnt <= w_trig ? '0 : r_dcnt + DCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_rd_ptr   <= '0;
      r_rd_cnt   <= '0;
      r_smpl_vld <= 1'b0;
    end else if (flush) begin
      r_state    <= StIdle;
      r_rd_ptr   <= '0;
      r_rd_cnt   <= '0;
      r_smpl_vld <= 1'b0;
    end else begin
      r_smpl_vld <= (r_state == StSeq);
      case (r_state)
        StIdle: begin
          if (w_trig) begin
            // oldest sample of the window that this write completes
            r_rd_ptr <= r_wr_ptr + ADDR_W'(1) - ADDR_W'(SEQ_LEN);
            r_rd_cnt <= '0;
            r_state  <= StSeq;
          end
        end
        StSeq: begin
          r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
          r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
          if (r_rd_cnt == ADDR_W'(SEQ_LEN - 1)) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // A trigger during an active window is dropped; setting beats clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr <= 1'b0;
    end else if (w_trig && r_state == StSeq) begin
      r_ovr <= 1'b1;
    end else if (clr_ovr) begin
      r_ovr <= 1'b0;
    end
  end

  assign lft_out    = r_lft_out;
  assign rght_out   = r_rght_out;
  assign sequencing = (r_state == StSeq);
  assign smpl_vld   = r_smpl_vld;
  assign fill_cnt   = r_fill_cnt;
  assign full       = (r_fill_cnt == (ADDR_W + 1)'(SEQ_LEN));
  assign ovr        = r_ovr;

endmodule

// File: tb/tb_smpl_seq_queue.sv
// Scoreboard bench for smpl_seq_queue: windows are queued when triggered and popped by
// per-instance monitors whenever smpl_vld is seen.
module tb_smpl_seq_queue;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned SL = 5;
  localparam logic [15:0] ROFS = 16'h0100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wrt = 1'b0;
  logic          wrt3 = 1'b0;
  logic          flush = 1'b0;
  logic          clr_ovr = 1'b0;
  logic [DW-1:0] lft = '0;
  logic [DW-1:0] rght = '0;

  logic [DW-1:0] lft_out, rght_out, lft_out3, rght_out3;
  logic          sequencing, smpl_vld, full, ovr;
  logic          sequencing3, smpl_vld3, full3, ovr3;
  logic [AW:0]   fill_cnt, fill_cnt3;

  int n_checks = 0;
  int n_errs = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp3_q[$];

  smpl_seq_queue #(.DATA_W(DW), .ADDR_W(AW), .SEQ_LEN(SL), .DECIM(1)) dut (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(wrt), .lft_smpl(lft), .rght_smpl(rght),
    .flush(flush), .clr_ovr(clr_ovr), .lft_out(lft_out), .rght_out(rght_out),
    .sequencing(sequencing), .smpl_vld(smpl_vld), .full(full), .fill_cnt(fill_cnt), .ovr(ovr)
  );

  smpl_seq_queue #(.DATA_W(DW), .ADDR_W(AW), .SEQ_LEN(SL), .DECIM(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(wrt3), .lft_smpl(lft), .rght_smpl(rght),
    .flush(flush), .clr_ovr(clr_ovr), .lft_out(lft_out3), .rght_out(rght_out3),
    .sequencing(sequencing3), .smpl_vld(smpl_vld3), .full(full3), .fill_cnt(fill_cnt3),
    .ovr(ovr3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (smpl_vld) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errs++;
        $display("FAIL dut1 unexpected sample: got %0d, none expected", lft_out);
      end else begin
        e = exp_q.pop_front();
        if (lft_out !== e || rght_out !== e + ROFS) begin
          n_errs++;
          $display("FAIL dut1 sample: got %0d/%0d expected %0d/%0d", lft_out, rght_out, e, e + ROFS);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (smpl_vld3) begin
      n_checks++;
      if (exp3_q.size() == 0) begin
        n_errs++;
        $display("FAIL dut3 unexpected sample: got %0d, none expected", lft_out3);
      end else begin
        e = exp3_q.pop_front();
        if (lft_out3 !== e || rght_out3 !== e + ROFS) begin
          n_errs++;
          $display("FAIL dut3 sample: got %0d/%0d expected %0d/%0d", lft_out3, rght_out3, e,
                   e + ROFS);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_gen(input int v, input bit to3);
    lft  = DW'(v);
    rght = DW'(v) + ROFS;
    if (to3) wrt3 = 1'b1;
    else wrt = 1'b1;
    tick();
    wrt  = 1'b0;
    wrt3 = 1'b0;
  endtask

  task automatic wr(input int v);
    wr_gen(v, 1'b0);
  endtask

  task automatic push_win(input int first);
    for (int i = 0; i < int'(SL); i++) exp_q.push_back(DW'(first + i));
  endtask

  task automatic push_win3(input int first);
    for (int i = 0; i < int'(SL); i++) exp3_q.push_back(DW'(first + i));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    // reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst fill_cnt", 32'(fill_cnt), 0);
    check("rst full", 32'(full), 0);
    check("rst sequencing", 32'(sequencing), 0);
    check("rst smpl_vld", 32'(smpl_vld), 0);
    check("rst ovr", 32'(ovr), 0);
    check("rst lft_out", 32'(lft_out), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // a) first full window
    for (int v = 1; v <= 4; v++) wr(v);
    check("a fill_cnt 4", 32'(fill_cnt), 4);
    check("a full before", 32'(full), 0);
    push_win(1);
    wr(5);
    check("a full", 32'(full), 1);
    n = 0;
    for (int i = 0; i < 20 && sequencing; i++) begin
      n++;
      tick();
    end
    check("a sequencing cycles", 32'(n), 5);
    repeat (3) tick();
    check("a window drained", 32'(exp_q.size()), 0);

    // b) sliding windows with pointer wrap
    for (int v = 6; v <= 12; v++) begin
      push_win(v - 4);
      wr(v);
      repeat (7) tick();
    end
    check("b windows drained", 32'(exp_q.size()), 0);
    check("b fill saturates", 32'(fill_cnt), 5);

    // d) overrun
    do_reset();
    for (int v = 1; v <= 4; v++) wr(v);
    push_win(1);
    wr(5);
    wr(6);
    check("d ovr set", 32'(ovr), 1);
    repeat (6) tick();
    check("d window drained", 32'(exp_q.size()), 0);
    check("d lft_out held", 32'(lft_out), 5);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("d ovr cleared", 32'(ovr), 0);
    push_win(3);
    wr(7);
    clr_ovr = 1'b1;
    wr(8);
    clr_ovr = 1'b0;
    check("d set wins over clr", 32'(ovr), 1);
    repeat (6) tick();
    check("d second window drained", 32'(exp_q.size()), 0);

    // e) flush mid-window, with a same-cycle write that must be discarded
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("e ovr kept by flush", 32'(ovr), 1);
    check("e fill after flush", 32'(fill_cnt), 0);
    for (int v = 1; v <= 4; v++) wr(v);
    push_win(1);
    wr(5);
    repeat (3) tick();
    flush = 1'b1;
    wrt = 1'b1;
    lft = 16'd99;
    rght = 16'd99 + ROFS;
    tick();
    flush = 1'b0;
    wrt = 1'b0;
    check("e smpl_vld after flush", 32'(smpl_vld), 0);
    check("e sequencing after flush", 32'(sequencing), 0);
    check("e fill_cnt after flush", 32'(fill_cnt), 0);
    check("e lft_out holds", 32'(lft_out), 3);
    check("e samples before flush", 32'(exp_q.size()), 2);
    exp_q.delete();
    for (int v = 11; v <= 14; v++) begin
      wr(v);
      repeat (3) tick();
    end
    repeat (8) tick();
    check("e fill_cnt 4", 32'(fill_cnt), 4);
    push_win(11);
    wr(15);
    repeat (8) tick();
    check("e fresh window drained", 32'(exp_q.size()), 0);

    // f) asynchronous reset mid-window
    do_reset();
    for (int v = 21; v <= 24; v++) wr(v);
    push_win(21);
    wr(25);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("f smpl_vld", 32'(smpl_vld), 0);
    check("f sequencing", 32'(sequencing), 0);
    check("f lft_out", 32'(lft_out), 0);
    check("f rght_out", 32'(rght_out), 0);
    check("f fill_cnt", 32'(fill_cnt), 0);
    check("f full", 32'(full), 0);
    check("f ovr", 32'(ovr), 0);
    check("f samples before reset", 32'(exp_q.size()), 4);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    for (int v = 31; v <= 34; v++) begin
      wr(v);
      repeat (3) tick();
    end
    repeat (8) tick();
    check("f no window yet", 32'(sequencing), 0);
    push_win(31);
    wr(35);
    repeat (8) tick();
    check("f fresh window drained", 32'(exp_q.size()), 0);

    // c) decimation by 3
    do_reset();
    for (int v = 1; v <= 11; v++) begin
      if (v == 7) push_win3(3);
      if (v == 10) push_win3(6);
      wr_gen(v, 1'b1);
      repeat (7) tick();
    end
    check("c windows drained", 32'(exp3_q.size()), 0);
    check("c ovr", 32'(ovr3), 0);
    check("c fill_cnt", 32'(fill_cnt3), 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/smpl_seq_queue.md
SMPL_SEQ_QUEUE -- requirements
Module: smpl_seq_queue

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  DATA_W, 16, sample width per channel
  ADDR_W, 10, queue depth is 2**ADDR_W
  SEQ_LEN, 1021, samples per sequenced window; legal range 2..2**ADDR_W-1
  DECIM, 1, one window is sequenced per DECIM qualifying writes; minimum 1
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  clock
  rst_n  in  1  reset, asynchronous, active-low
  wrt_smpl  in  1  one-cycle strobe; write lft_smpl/rght_smpl
  lft_smpl, rght_smpl  in  DATA_W  new samples
  flush  in  1  synchronous queue clear
  clr_ovr  in  1  clears ovr
  lft_out, rght_out  out  DATA_W  sequenced samples, registered
  sequencing  out  1  read window active (address phase)
  smpl_vld  out  1  lft_out/rght_out hold a window sample this cycle
  full  out  1  fill_cnt == SEQ_LEN
  fill_cnt  out  ADDR_W+1  samples held, saturating at SEQ_LEN
  ovr  out  1  sticky: trigger dropped because a window was in progress

Function
REQ-003 Storage SHALL be two internal inferred dual-port arrays of depth 2**ADDR_W x DATA_W: one write port and one read port, synchronous write, and synchronous read with 1-cycle latency into lft_out/rght_out.
REQ-004 Every wrt_smpl SHALL be accepted in both FSM states: the write lands at wr_ptr, then wr_ptr increments modulo 2**ADDR_W (wrap-around from 2**ADDR_W-1 to 0).
REQ-005 fill_cnt SHALL increment on each accepted write until it reaches SEQ_LEN, then hold; full SHALL be combinational from fill_cnt.
REQ-006 A qualifying write SHALL be one where the pre-write fill_cnt >= SEQ_LEN-1, i.e. the window is complete after that write.
REQ-007 A decimation counter dcnt (0..DECIM-1) SHALL advance only on qualifying writes; a trigger occurs when dcnt == DECIM-1, and dcnt then returns to 0.
REQ-008 The FSM SHALL have states IDLE and SEQ.
  IDLE + trigger: load rd_ptr = (pre-write wr_ptr + 1 - SEQ_LEN) mod 2**ADDR_W (the oldest sample), clear rd_cnt, go to SEQ.
  SEQ: present rd_ptr to the read port, increment rd_ptr (wrapping) and rd_cnt; after SEQ_LEN reads, return to IDLE.
REQ-009 sequencing SHALL be high exactly in SEQ, for exactly SEQ_LEN consecutive cycles per window.
REQ-010 smpl_vld SHALL be sequencing delayed by one cycle. With a trigger write at edge T, smpl_vld is high in cycles T+2..T+SEQ_LEN+1; samples are delivered oldest first, and the last one is the trigger sample.
REQ-011 Writes during SEQ SHALL NOT corrupt the window in progress, which holds because SEQ_LEN <= depth-1 and writes move forward from the window end.
REQ-012 A trigger arriving in SEQ SHALL be dropped (no restart, no queuing) and SHALL set ovr; dcnt still returns to 0.
REQ-013 ovr SHALL stay set until clr_ovr; if set and clr_ovr occur in the same cycle, set SHALL win.
REQ-014 flush SHALL, on the next edge:
  zero wr_ptr, rd_ptr, rd_cnt, fill_cnt and dcnt;
  force IDLE, so sequencing and smpl_vld are low the following cycle;
  leave ovr unchanged.
  flush SHALL take priority over a same-cycle wrt_smpl, which is discarded.
REQ-015 lft_out/rght_out SHALL hold their last read value while smpl_vld is low.

Reset
REQ-016 With rst_n low, asynchronously:
  state = IDLE; all pointers, counters and fill_cnt = 0;
  ovr, sequencing, smpl_vld, full = 0;
  lft_out, rght_out = 0.
REQ-017 Array contents SHALL NOT be reset; stale data SHALL be unreachable until SEQ_LEN new writes have occurred.
REQ-018 Reset asserted mid-window SHALL abort the window immediately, with no further smpl_vld.

Verification
REQ-019 The bench SHALL cover these directed scenarios (ADDR_W=3, SEQ_LEN=5, DECIM=1 unless stated):
  a) Write 1..5 -> on the write of 5, full=1; sequencing high 5 cycles; smpl_vld outputs 1,2,3,4,5.
  b) Continue writing 6..12, one write per 8 cycles -> windows are 2..6, 3..7, ... 8..12, with correct pointer wrap past address 7.
  c) DECIM=3, write 1..11 -> triggers only on writes 7 and 10; windows 3..7 and 6..10.
  d) Write 6 on the cycle after the trigger for 1..5 -> window remains 1..5, ovr=1; clr_ovr -> ovr=0; same-cycle set+clr -> ovr=1.
  e) flush at the third smpl_vld cycle -> smpl_vld=0 next cycle, fill_cnt=0; the next window needs 5 fresh writes.
  f) rst_n low mid-window -> all outputs 0 immediately; no smpl_vld until 5 new writes.
